// File: rtl/serial_pattern_detector_if.sv
// Serial pattern detector port bundle. The detector takes the slave side and the stream source takes the master side.
interface serial_pattern_detector_if #(
  parameter int CNT_W = 4
);
  logic             en;
  logic             din;
  logic             clr;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             full;
  logic             dbg_state;

  // Qualifier semantics: a din bit is consumed only on a rising clock edge
  // where en=1, and there is no back-pressure. clr wins over en on the same edge.
  modport master (output en, din, clr, input match, match_cnt, full, dbg_state);
  modport slave  (input en, din, clr, output match, match_cnt, full, dbg_state);
endinterface

// File: rtl/serial_pattern_detector.sv
// Finds a fixed PAT_LEN-bit pattern in a qualified serial stream.
// Each hit produces a one-cycle MATCH pulse and bumps a saturating counter.
module serial_pattern_detector #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  serial_pattern_detector_if.slave      bus
);
  localparam int               FW       = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [PAT_LEN-1:0]   hist_q, hist_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic                 match_q, match_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [PAT_LEN-1:0]   hist_next;
  logic [FW-1:0]        fill_inc;
  logic                 hit;

  // The match decision uses the history as it will be after this bit is accepted.
  // The fill check keeps a partly filled history from matching.
  assign hist_next = {hist_q[PAT_LEN-2:0], bus.din};
  assign fill_inc  = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
  assign hit       = (hist_next == PATTERN) && (fill_inc == FILL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;
    if (bus.clr) begin
      state_d = FILL;
      hist_d  = '0;
      fill_d  = '0;
      cnt_d   = '0;
    end else if (bus.en) begin
      hist_d = hist_next;
      fill_d = fill_inc;
      if (fill_inc == FILL_MAX) state_d = RUN;
      if (hit) begin
        match_d = 1'b1;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        // Non-overlapping mode starts the next search from an empty history.
        if (!OVERLAP) begin
          state_d = FILL;
          hist_d  = '0;
          fill_d  = '0;
        end
      end
    end
  end

  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.full      = (state_q == RUN);
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_serial_pattern_detector.sv
// Bench for serial_pattern_detector. It runs three builds side by side: overlap, non-overlap, and a 2-bit counter.
module tb_serial_pattern_detector;
  localparam int PAT_LEN = 4;
  localparam int PAT     = 'b1011;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 if (clk_run) clk = ~clk;

  serial_pattern_detector_if #(.CNT_W(4)) if_a ();
  serial_pattern_detector_if #(.CNT_W(4)) if_b ();
  serial_pattern_detector_if #(.CNT_W(2)) if_c ();

  serial_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(4))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  serial_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(4))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  serial_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  logic       dut_match [3];
  logic [3:0] dut_cnt   [3];
  logic       dut_full  [3];
  assign dut_match[0] = if_a.match;
  assign dut_match[1] = if_b.match;
  assign dut_match[2] = if_c.match;
  assign dut_cnt[0]   = if_a.match_cnt;
  assign dut_cnt[1]   = if_b.match_cnt;
  assign dut_cnt[2]   = {2'b00, if_c.match_cnt};
  assign dut_full[0]  = if_a.full;
  assign dut_full[1]  = if_b.full;
  assign dut_full[2]  = if_c.full;

  // Reference model: number of accepted bits since the last discard, plus a sliding window of the most recent bits.
  int ovl  [3] = '{1, 0, 1};
  int cmax [3] = '{15, 15, 3};
  int m_len [3];
  int m_win [3];
  int m_cnt [3];
  int m_match [3];

  typedef struct {
    logic       en;
    logic       din;
    logic       clr;
    logic       exp_match;
    logic [3:0] exp_cnt;
    logic       exp_full;
  } vec_t;
  vec_t vecs [7];

  logic [1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_len[i] = 0; m_win[i] = 0; m_cnt[i] = 0; m_match[i] = 0;
    end
  endtask

  task automatic model_update(input logic e, input logic d, input logic c);
    for (int i = 0; i < 3; i++) begin
      m_match[i] = 0;
      if (c) begin
        m_len[i] = 0; m_win[i] = 0; m_cnt[i] = 0;
      end else if (e) begin
        m_win[i] = ((m_win[i] * 2) + int'(d)) % (1 << PAT_LEN);
        m_len[i] = m_len[i] + 1;
        if (m_len[i] >= PAT_LEN && m_win[i] == PAT) begin
          m_match[i] = 1;
          if (m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
          if (ovl[i] == 0) begin
            m_len[i] = 0; m_win[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_models();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model_match[%0d]", i), 32'(dut_match[i]), 32'(m_match[i]));
      check($sformatf("model_cnt[%0d]", i), 32'(dut_cnt[i]), 32'(m_cnt[i]));
      check($sformatf("model_full[%0d]", i), 32'(dut_full[i]), 32'(m_len[i] >= PAT_LEN));
    end
  endtask

  task automatic set_in(input logic e, input logic d, input logic c);
    if_a.en = e; if_a.din = d; if_a.clr = c;
    if_b.en = e; if_b.din = d; if_b.clr = c;
    if_c.en = e; if_c.din = d; if_c.clr = c;
  endtask

  // Drive at the falling edge, let one rising edge pass, then compare at the next falling edge.
  task automatic step(input logic e, input logic d, input logic c);
    set_in(e, d, c);
    @(posedge clk);
    model_update(e, d, c);
    @(negedge clk);
    check_models();
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_match[%0d]", tag, i), 32'(dut_match[i]), 32'd0);
      check($sformatf("%s_cnt[%0d]", tag, i), 32'(dut_cnt[i]), 32'd0);
      check($sformatf("%s_full[%0d]", tag, i), 32'(dut_full[i]), 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bits5 [13] = '{1,0,1,1,0,1,1,0,1,1,0,1,1};
    int bits2 [7]  = '{1,0,1,1,0,1,1};
    int pulses;
    int pulses_b;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 1'b1};

    // Async reset applied with the clock stopped.
    set_in(1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #2 check_all_zero("rst_async");
    #5 rst_n = 1'b1;
    #2 check_all_zero("rst_release");
    model_reset();
    clk_run = 1'b1;
    @(negedge clk);

    // Overlapping stream, checked against a table of expected outputs.
    step(1'b0, 1'b0, 1'b1);
    pulses_b = 0;
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].en, vecs[i].din, vecs[i].clr);
      check($sformatf("tbl_match[%0d]", i), 32'(if_a.match), 32'(vecs[i].exp_match));
      check($sformatf("tbl_cnt[%0d]", i), 32'(if_a.match_cnt), 32'(vecs[i].exp_cnt));
      check($sformatf("tbl_full[%0d]", i), 32'(if_a.full), 32'(vecs[i].exp_full));
      if (if_b.match) pulses_b++;
    end
    // The non-overlapping build sees a single hit, and FULL drops afterwards.
    check("novl_pulses", 32'(pulses_b), 32'd1);
    check("novl_cnt", 32'(if_b.match_cnt), 32'd1);
    check("novl_full", 32'(if_b.full), 32'd0);

    // The same stream with EN=0 gaps while DIN toggles.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'(bits2[i]), 1'b0);
      for (int g = $urandom_range(1, 3); g > 0; g--) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        check("gap_match", 32'(if_a.match), 32'd0);
      end
    end
    check("gap_cnt_a", 32'(if_a.match_cnt), 32'd2);
    check("gap_cnt_b", 32'(if_b.match_cnt), 32'd1);

    // The 2-bit counter saturates while MATCH keeps pulsing.
    step(1'b0, 1'b0, 1'b1);
    exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd3);
    pulses = 0;
    for (int i = 0; i < 13; i++) begin
      step(1'b1, 1'(bits5[i]), 1'b0);
      if (if_c.match) begin
        pulses++;
        if (exp_q.size() == 0) check("sat_extra_pulse", 32'd1, 32'd0);
        else check("sat_cnt", 32'(if_c.match_cnt), 32'(exp_q.pop_front()));
      end
    end
    check("sat_pulses", 32'(pulses), 32'd4);

    // Reset arriving mid-stream throws away the partial history.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    check("rst_mid_match", 32'(if_a.match), 32'd0);
    check("rst_mid_full", 32'(if_a.full), 32'd0);

    // CLR on the edge that carries the final pattern bit suppresses the match.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("clr_match", 32'(if_a.match), 32'd0);
    check("clr_cnt", 32'(if_a.match_cnt), 32'd0);
    check("clr_full", 32'(if_a.full), 32'd0);

    // Random traffic checked against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 127) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
